// File: rtl/watch_pkg.sv
// Shared constants and field types for the watch timekeeping datapath.
// Optional build macro WATCH_HOUR12_EN selects the 12-hour constants in the top.
package watch_pkg;

  localparam int MSEC_MOD = 100;
  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  // 12-hour display: hour runs HOUR12_FIRST..HOUR12_FIRST+HOUR12_MOD-1 (1..12),
  // and the AM/PM flag flips when the hour leaves HOUR12_PM_FLIP (11 -> 12).
  localparam int HOUR12_MOD     = 12;
  localparam int HOUR12_FIRST   = 1;
  localparam int HOUR12_RESET   = 12;
  localparam int HOUR12_PM_FLIP = 11;

  typedef logic [MSEC_W-1:0] msec_t;
  typedef logic [SEC_W-1:0]  sec_t;
  typedef logic [MIN_W-1:0]  min_t;
  typedef logic [HOUR_W-1:0] hour_t;

endpackage

// File: rtl/watch_time_counter_if.sv
// Control and time-value bundle between the watch controller and the
// timekeeping datapath. The datapath takes the slave side.
// Optional build macro WATCH_HOUR12_EN changes only the meaning of hour/o_pm.
interface watch_time_counter_if;

  logic              i_run;
  logic              i_clear;
  logic              i_sec_up;
  logic              i_min_up;
  logic              i_hour_up;
  watch_pkg::msec_t  msec;
  watch_pkg::sec_t   sec;
  watch_pkg::min_t   min;
  watch_pkg::hour_t  hour;
  logic              o_pm;
  logic              o_sec_tick;

  modport master (
    output i_run, i_clear, i_sec_up, i_min_up, i_hour_up,
    input  msec, sec, min, hour, o_pm, o_sec_tick
  );

  modport slave (
    input  i_run, i_clear, i_sec_up, i_min_up, i_hour_up,
    output msec, sec, min, hour, o_pm, o_sec_tick
  );

endinterface

// File: rtl/watch_field_counter.sv
// One cascaded time field: counts MIN_VAL..MIN_VAL+MOD-1 and wraps.
// Advances on either a manual increment or a carry from the field below;
// the top guarantees the two never request an advance in the same cycle.
// carry_out only reflects carry_in, so manual increments never ripple upward.
// Optional build macro WATCH_HOUR12_EN is handled by the top (MIN_VAL=1 for hours).
module watch_field_counter #(
  parameter int MOD     = 60,
  parameter int WIDTH   = 6,
  parameter int MIN_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             carry_in,
  output logic [WIDTH-1:0] value,
  output logic             carry_out
);

  localparam logic [WIDTH-1:0] LOW_VAL  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] HIGH_VAL = WIDTH'(MIN_VAL + MOD - 1);

  logic advance;
  logic at_high;

  assign advance   = inc | carry_in;
  assign at_high   = (value == HIGH_VAL);
  assign carry_out = carry_in & at_high;

  // Field register: reset/clear load, otherwise step with wrap on advance
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= load_val;
    end else if (advance) begin
      value <= at_high ? LOW_VAL : value + 1'b1;
    end
  end

endmodule

// File: rtl/watch_time_counter.sv
// Watch timekeeping datapath: prescaler producing the centisecond tick,
// cascaded msec/sec/min/hour counters with a single-edge carry chain,
// run/stop, synchronous clear and manual per-field setting while stopped.
// Optional build macro WATCH_HOUR12_EN: hour counts 1..12 with an AM/PM flag;
// when undefined hour counts 0..23 and o_pm is tied low.
module watch_time_counter
  import watch_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int RESET_HOUR = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  watch_time_counter_if.slave  bus
);

  localparam int DIV     = CLK_FREQ / TICK_HZ;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

`ifdef WATCH_HOUR12_EN
  localparam int    HOUR_SEL_MOD = HOUR12_MOD;
  localparam int    HOUR_SEL_MIN = HOUR12_FIRST;
  localparam hour_t HOUR_LOAD    = HOUR_W'(HOUR12_RESET);
`else
  localparam int    HOUR_SEL_MOD = HOUR_MOD;
  localparam int    HOUR_SEL_MIN = 0;
  localparam hour_t HOUR_LOAD    = HOUR_W'(RESET_HOUR);
`endif

  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic               up_en;
  logic               sec_inc;
  logic               min_inc;
  logic               hour_inc;
  logic               msec_carry;
  logic               sec_carry;
  logic               min_carry;
  logic               day_carry_unused;
  logic               sec_tick_q;
  msec_t              msec_val;
  sec_t               sec_val;
  min_t               min_val;
  hour_t              hour_val;

  // Tick only fires while running and never in a clear cycle; manual setting
  // is accepted only while stopped, and clear also masks it.
  assign tick     = bus.i_run & ~bus.i_clear & (presc == PRESC_LAST);
  assign up_en    = ~bus.i_run & ~bus.i_clear;
  assign sec_inc  = up_en & bus.i_sec_up;
  assign min_inc  = up_en & bus.i_min_up;
  assign hour_inc = up_en & bus.i_hour_up;

  // Prescaler: counts only while running and holds its partial period when stopped
  always_ff @(posedge clk) begin
    if (reset || bus.i_clear) begin
      presc <= '0;
    end else if (bus.i_run) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  watch_field_counter #(
    .MOD     (MSEC_MOD),
    .WIDTH   (MSEC_W),
    .MIN_VAL (0)
  ) u_msec (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.i_clear),
    .load_val  ('0),
    .inc       (1'b0),
    .carry_in  (tick),
    .value     (msec_val),
    .carry_out (msec_carry)
  );

  watch_field_counter #(
    .MOD     (SEC_MOD),
    .WIDTH   (SEC_W),
    .MIN_VAL (0)
  ) u_sec (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.i_clear),
    .load_val  ('0),
    .inc       (sec_inc),
    .carry_in  (msec_carry),
    .value     (sec_val),
    .carry_out (sec_carry)
  );

  watch_field_counter #(
    .MOD     (MIN_MOD),
    .WIDTH   (MIN_W),
    .MIN_VAL (0)
  ) u_min (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.i_clear),
    .load_val  ('0),
    .inc       (min_inc),
    .carry_in  (sec_carry),
    .value     (min_val),
    .carry_out (min_carry)
  );

  watch_field_counter #(
    .MOD     (HOUR_SEL_MOD),
    .WIDTH   (HOUR_W),
    .MIN_VAL (HOUR_SEL_MIN)
  ) u_hour (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.i_clear),
    .load_val  (HOUR_LOAD),
    .inc       (hour_inc),
    .carry_in  (min_carry),
    .value     (hour_val),
    .carry_out (day_carry_unused)
  );

  // Second-tick strobe: registered copy of the msec-to-sec carry
  always_ff @(posedge clk) begin
    if (reset || bus.i_clear) begin
      sec_tick_q <= 1'b0;
    end else begin
      sec_tick_q <= msec_carry;
    end
  end

`ifdef WATCH_HOUR12_EN
  logic hour_adv;
  logic pm_q;

  assign hour_adv = hour_inc | min_carry;

  // AM/PM flag: flips whenever the hour steps from 11 to 12, by carry or by hand
  always_ff @(posedge clk) begin
    if (reset || bus.i_clear) begin
      pm_q <= 1'b0;
    end else if (hour_adv && (hour_val == HOUR_W'(HOUR12_PM_FLIP))) begin
      pm_q <= ~pm_q;
    end
  end

  assign bus.o_pm = pm_q;
`else
  assign bus.o_pm = 1'b0;
`endif

  assign bus.msec       = msec_val;
  assign bus.sec        = sec_val;
  assign bus.min        = min_val;
  assign bus.hour       = hour_val;
  assign bus.o_sec_tick = sec_tick_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed bench for watch_time_counter with CLK_FREQ=10, TICK_HZ=1
// (one msec step every 10 clocks). Expected values are hand-computed.
// Optional build macro WATCH_HOUR12_EN switches the hour expectations.
module tb_watch_time_counter;

  localparam int CLK_FREQ   = 10;
  localparam int TICK_HZ    = 1;
  localparam int RESET_HOUR = 12;

`ifdef WATCH_HOUR12_EN
  localparam int H_SET   = 11;
  localparam int H_WRAP  = 12;
  localparam int PM_WRAP = 1;
`else
  localparam int H_SET   = 23;
  localparam int H_WRAP  = 0;
  localparam int PM_WRAP = 0;
`endif

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  watch_time_counter_if bus ();

  watch_time_counter #(
    .CLK_FREQ   (CLK_FREQ),
    .TICK_HZ    (TICK_HZ),
    .RESET_HOUR (RESET_HOUR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic run, input logic clr,
                               input logic su, input logic mu, input logic hu);
    bus.i_run     = run;
    bus.i_clear   = clr;
    bus.i_sec_up  = su;
    bus.i_min_up  = mu;
    bus.i_hour_up = hu;
  endtask

  task automatic checkOutput(input string tag, input int e_hour, input int e_min,
                             input int e_sec, input int e_msec, input int e_pm,
                             input int e_tick);
    logic [25:0] obs;
    logic [25:0] exp_v;
    obs   = {bus.hour, bus.min, bus.sec, bus.msec, bus.o_pm, bus.o_sec_tick};
    exp_v = {5'(e_hour), 6'(e_min), 6'(e_sec), 7'(e_msec), 1'(e_pm), 1'(e_tick)};
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d:%0d:%0d.%0d pm=%0b tick=%0b, expected %0d:%0d:%0d.%0d pm=%0d tick=%0d",
             tag, bus.hour, bus.min, bus.sec, bus.msec, bus.o_pm, bus.o_sec_tick,
             e_hour, e_min, e_sec, e_msec, e_pm, e_tick);
    end
  endtask

  // Directed test sequence
  initial begin
    clk          = 1'b0;
    reset        = 1'b1;
    tests_run    = 0;
    tests_failed = 0;
    applyStimulus(0, 0, 0, 0, 0);

    step(2);
    checkOutput("reset_state", 12, 0, 0, 0, 0, 0);

    // Run from reset: first tick after 10 clocks, sec rollover after 1000
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    step(9);
    checkOutput("pre_first_tick", 12, 0, 0, 0, 0, 0);
    step(1);
    checkOutput("first_tick", 12, 0, 0, 1, 0, 0);
    step(989);
    checkOutput("msec_99", 12, 0, 0, 99, 0, 0);
    step(1);
    checkOutput("msec_rollover", 12, 0, 1, 0, 0, 1);
    step(1);
    checkOutput("sec_tick_one_cycle", 12, 0, 1, 0, 0, 0);

    // Stopped clear, then set H_SET:59:59 with simultaneous up pulses
    applyStimulus(0, 1, 0, 0, 0);
    step(1);
    checkOutput("clear_stopped", 12, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 1);
    step(11);
    applyStimulus(0, 0, 1, 1, 0);
    step(48);
    applyStimulus(0, 0, 0, 0, 0);
    step(1);
    checkOutput("set_time", H_SET, 59, 59, 0, 0, 0);

    // Run 99 ticks to reach .99, then one tick rolls every field
    applyStimulus(1, 0, 0, 0, 0);
    step(990);
    checkOutput("before_day_wrap", H_SET, 59, 59, 99, 0, 0);
    step(9);
    checkOutput("day_wrap_pending", H_SET, 59, 59, 99, 0, 0);
    step(1);
    checkOutput("day_wrap", H_WRAP, 0, 0, 0, PM_WRAP, 1);
    step(1);

    // Manual sec_up wraps at 59 without carrying into minutes
    applyStimulus(0, 0, 1, 0, 0);
    step(59);
    checkOutput("sec_up_to_59", H_WRAP, 0, 59, 0, PM_WRAP, 0);
    step(1);
    checkOutput("sec_up_wrap_no_carry", H_WRAP, 0, 0, 0, PM_WRAP, 0);

    // Up pulses are ignored while running (prescaler goes 1 -> 2)
    applyStimulus(1, 0, 1, 1, 1);
    step(1);
    checkOutput("up_ignored_running", H_WRAP, 0, 0, 0, PM_WRAP, 0);

    // Clear at prescaler 5, then a full 10-clock period to the next tick
    applyStimulus(1, 0, 0, 0, 0);
    step(3);
    applyStimulus(1, 1, 0, 0, 0);
    step(1);
    checkOutput("clear_mid_count", 12, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    step(9);
    checkOutput("after_clear_9clk", 12, 0, 0, 0, 0, 0);
    step(1);
    checkOutput("after_clear_10clk", 12, 0, 0, 1, 0, 0);

    // Stopping holds the prescaler's partial period
    step(4);
    applyStimulus(0, 0, 0, 0, 0);
    step(20);
    applyStimulus(1, 0, 0, 0, 0);
    step(5);
    checkOutput("hold_resume_pending", 12, 0, 0, 1, 0, 0);
    step(1);
    checkOutput("hold_resume_tick", 12, 0, 0, 2, 0, 0);

    // Reset dominates clear and up pulses, and holds while asserted
    reset = 1'b1;
    applyStimulus(0, 1, 1, 1, 1);
    step(1);
    checkOutput("reset_priority", 12, 0, 0, 0, 0, 0);
    step(5);
    checkOutput("reset_held", 12, 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    step(1);

    // Manual hour stepping across the hour range boundary
`ifdef WATCH_HOUR12_EN
    applyStimulus(0, 0, 0, 0, 1);
    step(11);
    checkOutput("hour12_to_11", 11, 0, 0, 0, 0, 0);
    step(1);
    checkOutput("hour12_11_to_12", 12, 0, 0, 0, 1, 0);
    step(1);
    checkOutput("hour12_12_to_1", 1, 0, 0, 0, 1, 0);
    step(11);
    checkOutput("hour12_second_flip", 12, 0, 0, 0, 0, 0);
`else
    applyStimulus(0, 0, 0, 0, 1);
    step(11);
    checkOutput("hour_to_23", 23, 0, 0, 0, 0, 0);
    step(1);
    checkOutput("hour_wrap_0", 0, 0, 0, 0, 0, 0);
`endif
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/watch_time_counter.md
Name: watch_time_counter

Overview:
Timekeeping datapath for the watch.
- Divides the system clock into a centisecond tick.
- Runs cascaded modulo counters: msec 0-99 (units of 10 ms), sec 0-59, min 0-59, hour 0-23.
- Outputs are registered binary values. They feed the watch digit splitter directly, which converts them to BCD digits for the FND display.
- Supports run/stop, synchronous clear, and manual per-field increment for time setting.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
TICK_HZ, 100, msec-field increment rate in Hz; CLK_FREQ/TICK_HZ must be an integer ≥ 2
RESET_HOUR, 12, hour value loaded by reset and clear (0-23)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
i_run  input  1  1 = time advances; 0 = stopped (set mode)
i_clear  input  1  synchronous clear pulse
i_sec_up  input  1  single-cycle pulse (debounced and edge-detected upstream); seconds +1
i_min_up  input  1  single-cycle pulse; minutes +1
i_hour_up  input  1  single-cycle pulse; hours +1
msec  output  7  0-99
sec  output  6  0-59
min  output  6  0-59
hour  output  5  0-23, or 1-12 with WATCH_HOUR12_EN
o_pm  output  1  PM flag (see Optional Feature)
o_sec_tick  output  1  one-cycle pulse in the cycle after sec changes due to carry

Behaviour:
- Reset values:
  - msec=0, sec=0, min=0, hour=RESET_HOUR.
  - o_pm=0; o_sec_tick=0.
  - Prescaler=0.
- Priority per cycle: reset > i_clear > manual up > tick advance.
- Prescaler:
  - Counts 0..CLK_FREQ/TICK_HZ-1 only while i_run=1.
  - At the terminal count it asserts internal tick and wraps to 0.
  - While i_run=0 it holds its value, so resuming does not lose the partial period.
- Tick advance (tick=1):
  - msec +1. At 99 it wraps to 0 and carries into sec.
  - sec at 59 with carry-in wraps to 0 and carries into min.
  - min at 59 wraps and carries into hour.
  - hour at 23 wraps to 0.
- All fields update on the same edge (combinational carry chain, registered outputs). Latency from tick to updated outputs is 1 clk.
- Example: 23:59:59.99 plus one tick gives 00:00:00.00 on the next edge.
- o_sec_tick: registered copy of the msec→sec carry. High exactly 1 cycle, one cycle after the carry.
- Manual up pulses are honoured only when i_run=0; they are ignored while running.
  - Each pulse increments its field modulo its range, with no carry into the next field (sec 59 +1 → 0; min unchanged).
  - Any combination of simultaneous up pulses each applies to its own field in the same cycle.
  - msec is not settable.
- i_clear:
  - Loads the reset values into all fields and the prescaler, and suppresses the tick and any up pulse in that cycle.
  - Asserted mid-count, the next tick occurs a full CLK_FREQ/TICK_HZ cycles after clear deasserts.
- Reset asserted mid-operation: identical to the power-up reset state on the next edge.
- Outputs never leave their legal ranges under any input sequence.

Optional Feature:
Macro WATCH_HOUR12_EN.
- Defined:
  - hour counts 1..12.
  - Transition 11→12 toggles o_pm; transition 12→1 does not.
  - Manual hour_up follows the same sequence and toggle rule.
  - Reset/clear load hour=12, o_pm=0; RESET_HOUR is ignored.
- Undefined:
  - hour counts 0..23.
  - o_pm is tied to 0.

Decomposition:
- Shared package watch_pkg holds:
  - MSEC_MOD=100, SEC_MOD=60, MIN_MOD=60, HOUR_MOD=24.
  - Field widths 7/6/6/5.
  - HOUR12 constants.
- Sub-module watch_field_counter, parameterised by MOD and WIDTH.
  - Inputs: clk, reset, clear, load_val, inc, carry_in.
  - Outputs: value, carry_out (= carry_in && value==MOD-1).
  - Instantiated once per field.
- The prescaler and hour-12 logic stay in the top.

Test Plan:
All scenarios use CLK_FREQ=10 and TICK_HZ=1 (tick every 10 clk).
- Reset, then i_run=1 for 1000 clk → msec=100 rollover seen: msec=0, sec=1, o_sec_tick high for exactly 1 cycle.
- Force-set 23:59:59 with i_run=0 via up pulses, msec at 99, then run one tick → outputs 00:00:00.00 one clk after tick.
- i_run=0, pulse i_sec_up at sec=59 → sec=0, min unchanged. Pulse i_sec_up while i_run=1 → no change.
- i_clear during a count at prescaler=5 → all fields reset (hour=12). The next msec increment occurs 10 clk after clear deasserts.
- reset asserted together with i_clear and all up pulses → reset values. Outputs hold reset values while reset stays high.
- WATCH_HOUR12_EN: hour 11 plus carry → hour=12, o_pm=1. Hour 12 plus carry → hour=1, o_pm=1. Second 11→12 → o_pm=0.
